// File: rtl/io_user_pkg.sv
// Shared constants and helpers for the board input-conditioning block.
package io_user_pkg;

   localparam int N_SW            = 4;
   localparam int N_BTN           = 4;
   localparam int DEF_DEBOUNCE_MS = 10;
   localparam int DEF_LONG_MS     = 1000;

   function automatic int ticks_per_ms(input int clk_hz);
      return clk_hz / 1000;
   endfunction

endpackage

// File: rtl/io_debounce_ch.sv
// One input channel: 2-flop synchroniser, tick-quantised debounce, edge pulses.
import io_user_pkg::*;

module io_debounce_ch #(
   parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
   input  logic I_CLK_100MHZ,
   input  logic I_RST,
   input  logic I_TICK,
   input  logic I_RAW,
   output logic O_LVL,
   output logic O_RISE,
   output logic O_FALL
);

   localparam int CW = $clog2(DEBOUNCE_MS + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          stable;
   logic          stable_d;
   logic          rise;
   logic          fall;

   always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
      if (I_RST) begin
         sync     <= '0;
         cnt      <= '0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
         rise     <= 1'b0;
         fall     <= 1'b0;
      end else begin
         sync <= {sync[0], I_RAW};
         // Any return to the stable level restarts the qualification window.
         if (sync[1] == stable) begin
            cnt <= '0;
         end else if (I_TICK) begin
            if (cnt == CW'(DEBOUNCE_MS - 1)) begin
               stable <= sync[1];
               cnt    <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
         stable_d <= stable;
         rise     <= stable & ~stable_d;
         fall     <= ~stable & stable_d;
      end
   end

   // stable_d is the registered level, so it lines up with the edge pulses.
   assign O_LVL  = stable_d;
   assign O_RISE = rise;
   assign O_FALL = fall;

endmodule

// File: rtl/io_user_inputs.sv
// Conditions Arty A7 switches and buttons: shared 1 ms tick, debounce, edge and long-press pulses.
import io_user_pkg::*;

module io_user_inputs #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
   parameter int LONG_MS     = DEF_LONG_MS
) (
   input  logic             I_CLK_100MHZ,
   input  logic             I_RST,
   input  logic [N_SW-1:0]  I_SW,
   input  logic [N_BTN-1:0] I_BTN,
   output logic [N_SW-1:0]  O_SW,
   output logic [N_SW-1:0]  O_SW_CHG,
   output logic [N_BTN-1:0] O_BTN,
   output logic [N_BTN-1:0] O_BTN_PRESS,
   output logic [N_BTN-1:0] O_BTN_RELEASE,
   output logic [N_BTN-1:0] O_BTN_LONG,
   output logic             O_TICK_1MS
);

   localparam int TPM = ticks_per_ms(CLK_FREQ_HZ);
   localparam int PW  = $clog2(TPM);
   localparam int LW  = $clog2(LONG_MS + 1);

   logic [PW-1:0]             pcnt;
   logic                      tick;
   logic [N_SW-1:0]           sw_rise;
   logic [N_SW-1:0]           sw_fall;
   logic [N_BTN-1:0][LW-1:0]  lcnt;
   logic [N_BTN-1:0]          long_p;

   always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
      if (I_RST) pcnt <= '0;
      else if (tick) pcnt <= '0;
      else pcnt <= pcnt + PW'(1);
   end

   assign tick       = (pcnt == PW'(TPM - 1));
   assign O_TICK_1MS = tick;

   for (genvar i = 0; i < N_SW; i++) begin : g_sw
      io_debounce_ch #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_ch (
         .I_CLK_100MHZ (I_CLK_100MHZ),
         .I_RST        (I_RST),
         .I_TICK       (tick),
         .I_RAW        (I_SW[i]),
         .O_LVL        (O_SW[i]),
         .O_RISE       (sw_rise[i]),
         .O_FALL       (sw_fall[i])
      );
   end

   assign O_SW_CHG = sw_rise | sw_fall;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      io_debounce_ch #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_ch (
         .I_CLK_100MHZ (I_CLK_100MHZ),
         .I_RST        (I_RST),
         .I_TICK       (tick),
         .I_RAW        (I_BTN[i]),
         .O_LVL        (O_BTN[i]),
         .O_RISE       (O_BTN_PRESS[i]),
         .O_FALL       (O_BTN_RELEASE[i])
      );
   end

   // Saturating hold counter: the pulse fires only on the LONG_MS-1 -> LONG_MS step.
   always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
      if (I_RST) begin
         lcnt   <= '0;
         long_p <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (!O_BTN[i]) lcnt[i] <= '0;
            else if (tick && lcnt[i] != LW'(LONG_MS)) lcnt[i] <= lcnt[i] + LW'(1);
            long_p[i] <= O_BTN[i] & tick & (lcnt[i] == LW'(LONG_MS - 1));
         end
      end
   end

   assign O_BTN_LONG = long_p;

endmodule

// File: tb/tb_io_user_inputs.sv
// Directed bench for io_user_inputs at 10 kHz (tick every 10 cycles), debounce 4 ms, long 20 ms.
module tb_io_user_inputs;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sw  = '0;
   logic [3:0] btn = '0;
   logic [3:0] o_sw, o_sw_chg, o_btn, o_press, o_release, o_long;
   logic       o_tick;

   io_user_inputs #(.CLK_FREQ_HZ(10_000), .DEBOUNCE_MS(4), .LONG_MS(20)) dut (
      .I_CLK_100MHZ  (clk),
      .I_RST         (rst),
      .I_SW          (sw),
      .I_BTN         (btn),
      .O_SW          (o_sw),
      .O_SW_CHG      (o_sw_chg),
      .O_BTN         (o_btn),
      .O_BTN_PRESS   (o_press),
      .O_BTN_RELEASE (o_release),
      .O_BTN_LONG    (o_long),
      .O_TICK_1MS    (o_tick)
   );

   always #5 clk = ~clk;

   // cyc is 1 in the first cycle after reset release; prescaler count = cyc-1.
   int cyc;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 1;
      else cyc <= cyc + 1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Pulse monitor, sampled mid-cycle on the falling edge.
   int tick_n = 0;
   int tick_at[3];
   int press_n[4], press_at[4], rel_n[4], rel_at[4], long_n[4], long_at[4], chg_n[4], chg_at[4];

   initial begin
      for (int i = 0; i < 4; i++) begin
         press_n[i] = 0; press_at[i] = -1; rel_n[i] = 0; rel_at[i] = -1;
         long_n[i]  = 0; long_at[i]  = -1; chg_n[i] = 0; chg_at[i] = -1;
      end
      for (int i = 0; i < 3; i++) tick_at[i] = -1;
   end

   always @(negedge clk) begin
      if (o_tick) begin
         if (tick_n < 3) tick_at[tick_n] = cyc;
         tick_n++;
      end
      for (int i = 0; i < 4; i++) begin
         if (o_press[i])   begin press_n[i]++; press_at[i] = cyc; end
         if (o_release[i]) begin rel_n[i]++;   rel_at[i]   = cyc; end
         if (o_long[i])    begin long_n[i]++;  long_at[i]  = cyc; end
         if (o_sw_chg[i])  begin chg_n[i]++;   chg_at[i]   = cyc; end
      end
   end

   function automatic int pulse_total();
      int s = 0;
      for (int i = 0; i < 4; i++) s += press_n[i] + rel_n[i] + long_n[i] + chg_n[i];
      return s;
   endfunction

   function automatic logic [31:0] all_outs();
      return {7'd0, o_sw, o_sw_chg, o_btn, o_press, o_release, o_long, o_tick};
   endfunction

   // Advance to posedge+1 of cycle c; inputs driven here land in cycle c.
   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   int tot;

   initial begin
      // Reset and idle
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", all_outs(), 0);
      rst = 1'b0;
      chk("first_cycle_outs", all_outs(), 0);
      wait_until(101);
      chk("tick_1", tick_at[0], 10);
      chk("tick_2", tick_at[1], 20);
      chk("tick_3", tick_at[2], 30);
      chk("tick_count_100", tick_n, 10);
      chk("idle_pulses", pulse_total(), 0);
      chk("idle_levels", {o_sw, o_btn}, 0);

      // Clean press on BTN1: sync at 105, ticks 110..140, pulse at 142
      wait_until(103); btn[1] = 1'b1;
      wait_until(200);
      chk("btn1_press_at", press_at[1], 142);
      chk("btn1_press_n", press_n[1], 1);
      chk("btn1_level", o_btn[1], 1);
      chk("btn1_no_long", long_n[1], 0);
      btn[1] = 1'b0;
      wait_until(260);
      chk("btn1_release_at", rel_at[1], 242);

      // Bouncy BTN2: early count of 2 is discarded, final rise synced at 332
      wait_until(300); btn[2] = 1'b1;
      wait_until(325); btn[2] = 1'b0;
      wait_until(330); btn[2] = 1'b1;
      wait_until(400);
      chk("btn2_press_n", press_n[2], 1);
      chk("btn2_press_at", press_at[2], 372);
      chk("btn2_no_release", rel_n[2], 0);
      btn[2] = 1'b0;

      // Long hold on BTN3: level up at 542, 20th tick at 740
      wait_until(500); btn[3] = 1'b1;
      wait_until(800); btn[3] = 1'b0;
      wait_until(901);
      chk("btn3_press_at", press_at[3], 542);
      chk("btn3_long_at", long_at[3], 741);
      chk("btn3_long_n", long_n[3], 1);
      chk("btn3_release_at", rel_at[3], 842);
      chk("btn3_release_n", rel_n[3], 1);

      // SW0 and BTN0 together
      wait_until(1000); sw[0] = 1'b1; btn[0] = 1'b1;
      wait_until(1101);
      chk("sw0_chg_at", chg_at[0], 1042);
      chk("btn0_press_at", press_at[0], 1042);
      chk("sw0_chg_n", chg_n[0], 1);
      chk("sw0_level", o_sw[0], 1);

      // Reset after two qualifying ticks on BTN1, button kept held
      wait_until(1103); btn[1] = 1'b1;
      wait_until(1125);
      tot = pulse_total();
      rst = 1'b1;
      #1;
      chk("midrst_outs", all_outs(), 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_no_pulse", pulse_total(), tot);
      chk("midrst_first_cycle", all_outs(), 0);
      wait_until(60);
      chk("btn1_repress_at", press_at[1], 42);
      chk("btn1_press_n_total", press_n[1], 2);
      chk("btn1_no_release", rel_n[1], 1);
      chk("btn0_repress_at", press_at[0], 42);
      chk("sw0_rechg_at", chg_at[0], 42);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
